// File: rtl/sd_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_responder
//  Purpose  : Card-side SD CMD line engine. Receives 48-bit host commands,
//             decodes index/argument and checks the frame, then transmits
//             a 48-bit response (with generated CRC7) in the Ncr window.
//  Revision : 1.0 - initial release
//
//  Parameters
//     NCR_MIN       min clocks from command end bit to response start bit
//     NCR_MAX       last clock after the end bit a response request is taken
//
//  Ports
//     iclk          SD clock, all activity on the rising edge
//     irst_n        asynchronous active-low reset
//     icmd_sd       CMD line as seen by the card (idle high)
//     ocmd_sd       CMD value driven by the card (1 when not enabled)
//     ocmd_sd_en    CMD output enable (pad tristates when low)
//     ocmd_valid    one-cycle pulse: good command decoded
//     ocmd_index    decoded command index (held)
//     ocmd_arg      decoded command argument (held)
//     ocmd_err      one-cycle pulse: CRC or end-bit failure
//     iresp_valid   response request pulse
//     iresp_index   response index field
//     iresp_arg     response payload
//     iresp_nocrc   send 7'h7F in place of the CRC (R3 style)
//     oresp_done    one-cycle pulse after the response end bit
//     oresp_timeout one-cycle pulse when no request arrived in the window
//
//  Build option
//     CMD_CRC_CHECK_EN  when defined, the received command CRC7 is verified
//                       and a mismatch is reported as a bad frame.
// ============================================================================
module sd_cmd_responder #(
   parameter int NCR_MIN = 2,
   parameter int NCR_MAX = 64
) (
   input  logic        iclk,
   input  logic        irst_n,
   input  logic        icmd_sd,
   output logic        ocmd_sd,
   output logic        ocmd_sd_en,
   output logic        ocmd_valid,
   output logic [5:0]  ocmd_index,
   output logic [31:0] ocmd_arg,
   output logic        ocmd_err,
   input  logic        iresp_valid,
   input  logic [5:0]  iresp_index,
   input  logic [31:0] iresp_arg,
   input  logic        iresp_nocrc,
   output logic        oresp_done,
   output logic        oresp_timeout
);

   // Wait counter must hold values up to the larger Ncr bound.
   localparam int NCR_TOP = (NCR_MAX > NCR_MIN) ? NCR_MAX : NCR_MIN;
   localparam int CW      = $clog2(NCR_TOP + 2);
   // Start-bit setup happens one edge before it appears on the line.
   localparam int MIN_M1  = (NCR_MIN > 0) ? NCR_MIN - 1 : 0;

   localparam logic [CW-1:0] C_NCR_MAX = CW'(NCR_MAX);
   localparam logic [CW-1:0] C_GO_CNT  = CW'(MIN_M1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RX        = 2'd1,
      ST_WAIT_RESP = 2'd2,
      ST_TX        = 2'd3
   } state_t;

   state_t         state_q;
   logic [5:0]     bit_cnt_q;     // index of the bit sampled/driven at this edge
   logic [CW-1:0]  wait_cnt_q;    // clocks elapsed since the command end bit
   logic [6:0]     crc_q;         // shared RX/TX CRC7 register
   logic [37:0]    rx_sr_q;       // received index + argument
   logic [39:0]    tx_sr_q;       // remaining response header/payload bits
   logic           resp_pend_q;   // request taken, waiting for NCR_MIN
   logic [5:0]     resp_index_q;
   logic [31:0]    resp_arg_q;
   logic           resp_nocrc_q;
   logic           cmd_sd_q;
   logic           cmd_sd_en_q;
   logic           cmd_valid_q;
   logic [5:0]     cmd_index_q;
   logic [31:0]    cmd_arg_q;
   logic           cmd_err_q;
   logic           resp_done_q;
   logic           resp_timeout_q;
`ifdef CMD_CRC_CHECK_EN
   logic           crc_bad_q;     // sticky: a received CRC bit disagreed
`endif

   logic [6:0]     crc_rx_d;
   logic [6:0]     crc_tx_d;
   logic           frame_good_d;
   logic [5:0]     sel_index_d;
   logic [31:0]    sel_arg_d;
   logic           sel_nocrc_d;
   logic           resp_go_d;

   // One serial step of CRC7, polynomial x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   always_comb begin
      crc_rx_d = crc7_step(crc_q, icmd_sd);
      crc_tx_d = crc7_step(crc_q, tx_sr_q[39]);
`ifdef CMD_CRC_CHECK_EN
      frame_good_d = icmd_sd & ~crc_bad_q;
`else
      frame_good_d = icmd_sd;
`endif
      // A request seen this very edge is used directly; otherwise the held one.
      sel_index_d = resp_pend_q ? resp_index_q : iresp_index;
      sel_arg_d   = resp_pend_q ? resp_arg_q   : iresp_arg;
      sel_nocrc_d = resp_pend_q ? resp_nocrc_q : iresp_nocrc;
      resp_go_d   = (resp_pend_q | iresp_valid) && (wait_cnt_q >= C_GO_CNT);
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         wait_cnt_q     <= '0;
         crc_q          <= '0;
         rx_sr_q        <= '0;
         tx_sr_q        <= '0;
         resp_pend_q    <= 1'b0;
         resp_index_q   <= '0;
         resp_arg_q     <= '0;
         resp_nocrc_q   <= 1'b0;
         cmd_sd_q       <= 1'b1;
         cmd_sd_en_q    <= 1'b0;
         cmd_valid_q    <= 1'b0;
         cmd_index_q    <= '0;
         cmd_arg_q      <= '0;
         cmd_err_q      <= 1'b0;
         resp_done_q    <= 1'b0;
         resp_timeout_q <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
         crc_bad_q      <= 1'b0;
`endif
      end else begin
         cmd_valid_q    <= 1'b0;
         cmd_err_q      <= 1'b0;
         resp_done_q    <= 1'b0;
         resp_timeout_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (!icmd_sd) begin
                  // Start bit is 0, so the CRC over it stays at 0.
                  state_q   <= ST_RX;
                  bit_cnt_q <= 6'd1;
                  crc_q     <= '0;
`ifdef CMD_CRC_CHECK_EN
                  crc_bad_q <= 1'b0;
`endif
               end
            end

            ST_RX: begin
               bit_cnt_q <= bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd1) begin
                  // Transmission bit 0 means card-to-host traffic: not ours.
                  if (!icmd_sd) begin
                     state_q <= ST_IDLE;
                  end else begin
                     crc_q <= crc_rx_d;
                  end
               end else if (bit_cnt_q < 6'd40) begin
                  rx_sr_q <= {rx_sr_q[36:0], icmd_sd};
                  crc_q   <= crc_rx_d;
               end else if (bit_cnt_q < 6'd47) begin
`ifdef CMD_CRC_CHECK_EN
                  crc_bad_q <= crc_bad_q | (icmd_sd ^ crc_q[6]);
`endif
                  crc_q <= {crc_q[5:0], 1'b0};
               end else begin
                  if (frame_good_d) begin
                     cmd_valid_q <= 1'b1;
                     cmd_index_q <= rx_sr_q[37:32];
                     cmd_arg_q   <= rx_sr_q[31:0];
                     resp_pend_q <= 1'b0;
                     wait_cnt_q  <= CW'(1);
                     state_q     <= ST_WAIT_RESP;
                  end else begin
                     cmd_err_q <= 1'b1;
                     state_q   <= ST_IDLE;
                  end
               end
            end

            ST_WAIT_RESP: begin
               wait_cnt_q <= wait_cnt_q + CW'(1);
               if (resp_go_d) begin
                  // Drive start bit now; the rest of the header follows.
                  cmd_sd_q     <= 1'b0;
                  cmd_sd_en_q  <= 1'b1;
                  tx_sr_q      <= {1'b0, sel_index_d, sel_arg_d, 1'b0};
                  resp_nocrc_q <= sel_nocrc_d;
                  crc_q        <= '0;
                  bit_cnt_q    <= 6'd1;
                  resp_pend_q  <= 1'b0;
                  state_q      <= ST_TX;
               end else if (!resp_pend_q && iresp_valid) begin
                  resp_pend_q  <= 1'b1;
                  resp_index_q <= iresp_index;
                  resp_arg_q   <= iresp_arg;
                  resp_nocrc_q <= iresp_nocrc;
               end else if (!resp_pend_q && (wait_cnt_q == C_NCR_MAX)) begin
                  resp_timeout_q <= 1'b1;
                  state_q        <= ST_IDLE;
               end
            end

            ST_TX: begin
               bit_cnt_q <= bit_cnt_q + 6'd1;
               if (bit_cnt_q < 6'd40) begin
                  cmd_sd_q <= tx_sr_q[39];
                  tx_sr_q  <= {tx_sr_q[38:0], 1'b0};
                  crc_q    <= crc_tx_d;
               end else if (bit_cnt_q < 6'd47) begin
                  // nocrc forces every CRC bit high (7'h7F).
                  cmd_sd_q <= resp_nocrc_q | crc_q[6];
                  crc_q    <= {crc_q[5:0], 1'b0};
               end else if (bit_cnt_q == 6'd47) begin
                  cmd_sd_q <= 1'b1;
               end else begin
                  cmd_sd_q    <= 1'b1;
                  cmd_sd_en_q <= 1'b0;
                  resp_done_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ocmd_sd       = cmd_sd_q;
   assign ocmd_sd_en    = cmd_sd_en_q;
   assign ocmd_valid    = cmd_valid_q;
   assign ocmd_index    = cmd_index_q;
   assign ocmd_arg      = cmd_arg_q;
   assign ocmd_err      = cmd_err_q;
   assign oresp_done    = resp_done_q;
   assign oresp_timeout = resp_timeout_q;

endmodule
`default_nettype wire
